// File: rtl/serializer_stream.sv
// serializer_stream: parallel-to-serial converter with a one-word holding
// register, per-word bit count and bit order, and sink backpressure.
// Optional feature macro: SERIALIZER_STREAM_PARITY_EN appends one even-parity
// bit after the final data bit of every emitted word.
module serializer_stream #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MOD_W   = $clog2(DATA_W),
  parameter int unsigned MIN_LEN = 3
) (
  input  logic              clk_i,
  input  logic              srst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_lsb_first_i,
  input  logic              data_val_i,
  output logic              data_rdy_o,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              ser_data_last_o,
  input  logic              ser_data_rdy_i,
  output logic              busy_o
);

  // One extra bit so a full DATA_W count (plus parity) never wraps.
  localparam int unsigned CNT_W = MOD_W + 1;
`ifdef SERIALIZER_STREAM_PARITY_EN
  localparam int unsigned TAIL_BITS = 1;
`else
  localparam int unsigned TAIL_BITS = 0;
`endif

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  sh_data_q, sh_data_d;
  logic               sh_lsb_q, sh_lsb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ser_bit_q, ser_bit_d;
  logic               ser_val_q, ser_val_d;
  logic               ser_last_q, ser_last_d;
  logic               busy_q, busy_d;
  logic [DATA_W-1:0]  hold_data_q, hold_data_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic               hold_lsb_q, hold_lsb_d;
  logic               hold_full_q, hold_full_d;
`ifdef SERIALIZER_STREAM_PARITY_EN
  logic               par_q, par_d;
`endif

  logic [CNT_W-1:0]   in_cnt_c;
  logic               in_drop_c;
  logic               accept_c;
  logic               take_c;
  logic               step_c;
  logic               final_c;
  logic               shifter_free_c;
  logic               load_en_c;
  logic [DATA_W-1:0]  load_data_c;
  logic [CNT_W-1:0]   load_cnt_c;
  logic               load_lsb_c;
  logic               first_bit_c;
  logic               next_bit_c;

  // Handshake: ready only when the holding register is free and not in reset.
  assign data_rdy_o = srst_n_i & ~hold_full_q;
  assign accept_c   = data_val_i & data_rdy_o;

  // Effective bit count of the incoming word; zero encodes a full word.
  assign in_cnt_c  = (data_mod_i == '0) ? CNT_W'(DATA_W) : CNT_W'(data_mod_i);
  assign in_drop_c = (data_mod_i != '0) && (in_cnt_c < CNT_W'(MIN_LEN));
  assign take_c    = accept_c & ~in_drop_c;

  // Shifter advances on a consumed bit; it frees up on the final bit.
  assign step_c         = ser_val_q & ser_data_rdy_i;
  assign final_c        = step_c & (cnt_q == CNT_W'(1));
  assign shifter_free_c = (state_q == ST_IDLE) | final_c;

  // Pick the next shifter word: holding register has priority over the input.
  always_comb begin
    load_en_c   = 1'b0;
    load_data_c = '0;
    load_cnt_c  = '0;
    load_lsb_c  = 1'b0;
    if (shifter_free_c) begin
      if (hold_full_q) begin
        load_en_c   = 1'b1;
        load_data_c = hold_data_q;
        load_cnt_c  = hold_cnt_q;
        load_lsb_c  = hold_lsb_q;
      end else if (take_c) begin
        load_en_c   = 1'b1;
        load_data_c = data_i;
        load_cnt_c  = in_cnt_c;
        load_lsb_c  = data_lsb_first_i;
      end
    end
  end

  // Holding register: capture when the shifter is busy, drain into the shifter.
  always_comb begin
    hold_data_d = hold_data_q;
    hold_cnt_d  = hold_cnt_q;
    hold_lsb_d  = hold_lsb_q;
    hold_full_d = hold_full_q;
    if (take_c && !shifter_free_c) begin
      hold_data_d = data_i;
      hold_cnt_d  = in_cnt_c;
      hold_lsb_d  = data_lsb_first_i;
      hold_full_d = 1'b1;
    end else if (shifter_free_c && hold_full_q) begin
      hold_full_d = 1'b0;
    end
  end

  // Shifter next state and registered serial outputs.
  always_comb begin
    state_d     = state_q;
    sh_data_d   = sh_data_q;
    sh_lsb_d    = sh_lsb_q;
    cnt_d       = cnt_q;
    ser_bit_d   = ser_bit_q;
    ser_val_d   = ser_val_q;
    ser_last_d  = ser_last_q;
`ifdef SERIALIZER_STREAM_PARITY_EN
    par_d       = par_q;
`endif
    next_bit_c  = sh_lsb_q ? sh_data_q[0] : sh_data_q[DATA_W-1];
    first_bit_c = load_lsb_c ? load_data_c[0] : load_data_c[DATA_W-1];

    if (step_c) begin
      if (cnt_q == CNT_W'(1)) begin
        state_d    = ST_IDLE;
        cnt_d      = '0;
        ser_val_d  = 1'b0;
        ser_bit_d  = 1'b0;
        ser_last_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
`ifdef SERIALIZER_STREAM_PARITY_EN
        if (cnt_d == CNT_W'(1)) begin
          // Accumulator already covers every emitted data bit.
          ser_bit_d = par_q;
        end else begin
          ser_bit_d = next_bit_c;
          sh_data_d = sh_lsb_q ? (sh_data_q >> 1) : (sh_data_q << 1);
          par_d     = par_q ^ next_bit_c;
        end
`else
        ser_bit_d = next_bit_c;
        sh_data_d = sh_lsb_q ? (sh_data_q >> 1) : (sh_data_q << 1);
`endif
        ser_last_d = (cnt_d == CNT_W'(1));
      end
    end

    // A load overrides the idle transition so back-to-back words have no gap.
    if (load_en_c) begin
      state_d    = ST_SHIFT;
      sh_lsb_d   = load_lsb_c;
      sh_data_d  = load_lsb_c ? (load_data_c >> 1) : (load_data_c << 1);
      cnt_d      = load_cnt_c + CNT_W'(TAIL_BITS);
      ser_val_d  = 1'b1;
      ser_bit_d  = first_bit_c;
      ser_last_d = (cnt_d == CNT_W'(1));
`ifdef SERIALIZER_STREAM_PARITY_EN
      par_d      = first_bit_c;
`endif
    end
  end

  // Busy reflects the state that will be present next cycle.
  always_comb begin
    busy_d = (state_d == ST_SHIFT) | hold_full_d;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q     <= ST_IDLE;
      sh_data_q   <= '0;
      sh_lsb_q    <= 1'b0;
      cnt_q       <= '0;
      ser_bit_q   <= 1'b0;
      ser_val_q   <= 1'b0;
      ser_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      hold_data_q <= '0;
      hold_cnt_q  <= '0;
      hold_lsb_q  <= 1'b0;
      hold_full_q <= 1'b0;
`ifdef SERIALIZER_STREAM_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sh_data_q   <= sh_data_d;
      sh_lsb_q    <= sh_lsb_d;
      cnt_q       <= cnt_d;
      ser_bit_q   <= ser_bit_d;
      ser_val_q   <= ser_val_d;
      ser_last_q  <= ser_last_d;
      busy_q      <= busy_d;
      hold_data_q <= hold_data_d;
      hold_cnt_q  <= hold_cnt_d;
      hold_lsb_q  <= hold_lsb_d;
      hold_full_q <= hold_full_d;
`ifdef SERIALIZER_STREAM_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign ser_data_o      = ser_bit_q;
  assign ser_data_val_o  = ser_val_q;
  assign ser_data_last_o = ser_last_q;
  assign busy_o          = busy_q;

endmodule
